// File: rtl/sid_stereo_mixer_if.sv
// Bus bundle for sid_stereo_mixer: sample input and start tick, gain/pan config
// write port, and the stereo result stream with its valid/ready handshake.
//   master : host side (drives samples, start, config, out_ready)
//   slave  : mixer side (drives out_l/out_r, out_valid, clip flags, overrun, busy)
interface sid_stereo_mixer_if #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned OUT_W    = 16
);
    logic [NUM_CH*SAMPLE_W-1:0] in_samples;
    logic                       start;
    logic                       cfg_we;
    logic [3:0]                 cfg_addr;
    logic [GAIN_W+1:0]          cfg_wdata;
    logic signed [OUT_W-1:0]    out_l;
    logic signed [OUT_W-1:0]    out_r;
    logic                       out_valid;
    logic                       out_ready;
    logic                       clip_l;
    logic                       clip_r;
    logic                       overrun;
    logic                       busy;

    modport master (
        output in_samples, start, cfg_we, cfg_addr, cfg_wdata, out_ready,
        input  out_l, out_r, out_valid, clip_l, clip_r, overrun, busy
    );

    modport slave (
        input  in_samples, start, cfg_we, cfg_addr, cfg_wdata, out_ready,
        output out_l, out_r, out_valid, clip_l, clip_r, overrun, busy
    );
endinterface

// File: rtl/sid_stereo_mixer.sv
// N-channel SID stereo mixer. On each start tick the channel samples are
// snapshotted, then gain-scaled and accumulated one channel per cycle into left
// and right accumulators according to each channel's pan bits. The sums are
// rescaled by the Q1.(GAIN_W-1) gain format, saturated to OUT_W and presented
// under a valid/ready handshake.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset
//   bus  : sid_stereo_mixer_if.slave (samples/start, config write, result stream,
//          clip flags, overrun pulse, busy)
module sid_stereo_mixer #(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned GAIN_W   = 8,
    parameter int unsigned OUT_W    = 16
) (
    input logic              clk,
    input logic              rst,
    sid_stereo_mixer_if.slave bus
);
    localparam int unsigned AccW  = SAMPLE_W + GAIN_W + $clog2(NUM_CH) + 1;
    localparam int unsigned ProdW = SAMPLE_W + GAIN_W + 1;
    localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [ChW-1:0]         LastCh = ChW'(NUM_CH - 1);
    localparam logic [GAIN_W-1:0]      Unity  = GAIN_W'(1) << (GAIN_W - 1);
    localparam logic signed [AccW-1:0] OutMax = {{(AccW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [AccW-1:0] OutMin = ~OutMax;

    typedef enum logic [1:0] {StIdle, StAcc, StSat, StOut} state_e;

    state_e                     state_q, state_d;
    logic [ChW-1:0]             ch_q, ch_d;
    logic signed [AccW-1:0]     acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic signed [SAMPLE_W-1:0] snap_q [NUM_CH];
    logic [GAIN_W-1:0]          gain_q [NUM_CH];
    logic [1:0]                 pan_q  [NUM_CH];
    logic signed [OUT_W-1:0]    out_l_q, out_l_d, out_r_q, out_r_d;
    logic                       clip_l_q, clip_l_d, clip_r_q, clip_r_d;
    logic                       overrun_q, overrun_d;
    logic                       load_snap;

    logic signed [ProdW-1:0]    samp_x, gain_x, prod;
    logic signed [AccW-1:0]     prod_ext, sh_l, sh_r;
    logic [OUT_W:0]             sat_l, sat_r;

    // Returns {clip, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [AccW-1:0] v);
        if (v > OutMax) begin
            return {1'b1, OutMax[OUT_W-1:0]};
        end else if (v < OutMin) begin
            return {1'b1, OutMin[OUT_W-1:0]};
        end
        return {1'b0, v[OUT_W-1:0]};
    endfunction

    // Gain is read live, so a config write landing on this channel's cycle
    // only takes effect from the next frame.
    always_comb begin
        samp_x   = ProdW'(snap_q[ch_q]);
        gain_x   = ProdW'({1'b0, gain_q[ch_q]});
        prod     = samp_x * gain_x;
        prod_ext = AccW'(prod);
        sh_l     = acc_l_q >>> (GAIN_W - 1);
        sh_r     = acc_r_q >>> (GAIN_W - 1);
        sat_l    = saturate(sh_l);
        sat_r    = saturate(sh_r);
    end

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        acc_l_d   = acc_l_q;
        acc_r_d   = acc_r_q;
        out_l_d   = out_l_q;
        out_r_d   = out_r_q;
        clip_l_d  = clip_l_q;
        clip_r_d  = clip_r_q;
        load_snap = 1'b0;
        overrun_d = bus.start && (state_q != StIdle);
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StAcc;
                    load_snap = 1'b1;
                    ch_d      = '0;
                    acc_l_d   = '0;
                    acc_r_d   = '0;
                end
            end
            StAcc: begin
                if (pan_q[ch_q][0]) acc_l_d = acc_l_q + prod_ext;
                if (pan_q[ch_q][1]) acc_r_d = acc_r_q + prod_ext;
                if (ch_q == LastCh) begin
                    state_d = StSat;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            StSat: begin
                out_l_d  = sat_l[OUT_W-1:0];
                clip_l_d = sat_l[OUT_W];
                out_r_d  = sat_r[OUT_W-1:0];
                clip_r_d = sat_r[OUT_W];
                state_d  = StOut;
            end
            StOut: begin
                if (bus.out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            acc_l_q   <= '0;
            acc_r_q   <= '0;
            out_l_q   <= '0;
            out_r_q   <= '0;
            clip_l_q  <= 1'b0;
            clip_r_q  <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                snap_q[k] <= '0;
                gain_q[k] <= Unity;
                pan_q[k]  <= 2'b11;
            end
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            acc_l_q   <= acc_l_d;
            acc_r_q   <= acc_r_d;
            out_l_q   <= out_l_d;
            out_r_q   <= out_r_d;
            clip_l_q  <= clip_l_d;
            clip_r_q  <= clip_r_d;
            overrun_q <= overrun_d;
            if (load_snap) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    snap_q[k] <= bus.in_samples[k*SAMPLE_W +: SAMPLE_W];
                end
            end
            if (bus.cfg_we && (32'(bus.cfg_addr) < NUM_CH)) begin
                gain_q[bus.cfg_addr[ChW-1:0]] <= bus.cfg_wdata[GAIN_W-1:0];
                pan_q[bus.cfg_addr[ChW-1:0]]  <= bus.cfg_wdata[GAIN_W+1:GAIN_W];
            end
        end
    end

    assign bus.out_l     = out_l_q;
    assign bus.out_r     = out_r_q;
    assign bus.clip_l    = clip_l_q;
    assign bus.clip_r    = clip_r_q;
    assign bus.out_valid = (state_q == StOut);
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state_q != StIdle);
endmodule

// File: tb/tb_sid_stereo_mixer.sv
// Directed bench for sid_stereo_mixer (NUM_CH=2, 16-bit samples, 8-bit gain).
// Inputs are driven and outputs sampled 1 ns after the rising edge.
module tb_sid_stereo_mixer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sid_stereo_mixer_if #(.NUM_CH(2), .SAMPLE_W(16), .GAIN_W(8), .OUT_W(16)) bus ();

    sid_stereo_mixer #(.NUM_CH(2), .SAMPLE_W(16), .GAIN_W(8), .OUT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cfg_wdata = {pan_r, pan_l, gain[7:0]}
    task automatic cfg(input logic [3:0] addr, input logic [9:0] data);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = addr;
        bus.cfg_wdata = data;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    // Returns one cycle after the start edge (first ACC cycle).
    task automatic start_frame(input logic signed [15:0] s0, input logic signed [15:0] s1);
        bus.in_samples = {s1, s0};
        bus.start      = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_edges);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, exp_edges);
    endtask

    task automatic check_result(input string tag, input int el, input int er,
                                input logic ecl, input logic ecr);
        check({tag, "_l"}, bus.out_l, el);
        check({tag, "_r"}, bus.out_r, er);
        check({tag, "_clip_l"}, bus.clip_l, ecl);
        check({tag, "_clip_r"}, bus.clip_r, ecr);
    endtask

    task automatic consume(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
    endtask

    task automatic frame(input string tag, input logic signed [15:0] s0,
                         input logic signed [15:0] s1, input int el, input int er,
                         input logic ecl, input logic ecr);
        start_frame(s0, s1);
        wait_valid(tag, 3);
        check_result(tag, el, er, ecl, ecr);
        consume(tag);
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_samples = '0;
        bus.start      = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_addr   = '0;
        bus.cfg_wdata  = '0;
        bus.out_ready  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_valid", bus.out_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_overrun", bus.overrun, 1'b0);
        check_result("rst", 0, 0, 1'b0, 1'b0);

        // Defaults: unity gain, both sides. (1000 - 200) = 800.
        frame("dflt", 16'sd1000, -16'sd200, 800, 800, 1'b0, 1'b0);

        // Gain: ch0 half, ch1 zero.
        cfg(4'd0, 10'h340);
        cfg(4'd1, 10'h300);
        frame("gain", 16'sd1000, 16'sd5000, 500, 500, 1'b0, 1'b0);
        frame("floor", -16'sd1001, 16'sd5000, -501, -501, 1'b0, 1'b0);

        // Pan: ch0 left only, ch1 right only, unity gains.
        cfg(4'd0, 10'h180);
        cfg(4'd1, 10'h280);
        frame("pan", 16'sd1234, -16'sd4321, 1234, -4321, 1'b0, 1'b0);
        cfg(4'd0, 10'h080);
        cfg(4'd1, 10'h080);
        frame("mute", 16'sd1234, -16'sd4321, 0, 0, 1'b0, 1'b0);

        // Saturation with unity gains on both sides.
        cfg(4'd0, 10'h380);
        cfg(4'd1, 10'h380);
        frame("sat_pos", 16'sd30000, 16'sd30000, 32767, 32767, 1'b1, 1'b1);
        frame("sat_neg", -16'sd32768, -16'sd32768, -32768, -32768, 1'b1, 1'b1);
        // Out-of-range address must not alias onto ch1.
        cfg(4'd3, 10'h000);
        frame("nosat", 16'sd16000, 16'sd16000, 32000, 32000, 1'b0, 1'b0);

        // Live config: write to ch1 during ch0's cycle applies to this frame.
        start_frame(16'sd1000, 16'sd1000);
        bus.cfg_we    = 1'b1;
        bus.cfg_addr  = 4'd1;
        bus.cfg_wdata = 10'h300;
        tick();
        bus.cfg_we = 1'b0;
        wait_valid("live", 2);
        check_result("live", 1000, 1000, 1'b0, 1'b0);
        consume("live");
        cfg(4'd1, 10'h380);

        // Backpressure with a dropped start in the middle.
        start_frame(16'sd100, 16'sd200);
        wait_valid("bp", 3);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.in_samples = {16'sd5000, 16'sd5000};
                bus.start      = 1'b1;
            end
            tick();
            bus.start = 1'b0;
            check("bp_valid", bus.out_valid, 1'b1);
            check("bp_l", bus.out_l, 300);
            check("bp_r", bus.out_r, 300);
            if (i == 4) check("bp_overrun", bus.overrun, 1'b1);
            if (i == 5) check("bp_overrun_end", bus.overrun, 1'b0);
        end
        consume("bp");
        frame("fresh", 16'sd7, 16'sd8, 15, 15, 1'b0, 1'b0);

        // Reset mid-frame restores unity gain and abandons the frame.
        cfg(4'd0, 10'h340);
        start_frame(16'sd1000, -16'sd200);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", bus.out_valid, 1'b0);
        check("mrst_busy", bus.busy, 1'b0);
        frame("after_rst", 16'sd1000, -16'sd200, 800, 800, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sid_stereo_mixer.md
Name: sid_stereo_mixer

Overview:
- Parametrised N-channel mixer between SID voice outputs (`sid.oOut`, one per SID instance) and the I2S transmitter.
- Generalises the single mono SID-to-I2S path to NUM_CH SIDs with per-channel gain and stereo pan.
- Each sample tick it snapshots all channel samples and runs a sequential gain/accumulate, one channel per cycle.
- Produces a saturated stereo pair under a valid/ready handshake. Gain and pan registers are written over a simple register-write port.

Parameters:
- NUM_CH, 2, number of input channels (1..16).
- SAMPLE_W, 16, signed input sample width.
- GAIN_W, 8, unsigned gain width. Gain is Q1.(GAIN_W-1), so 0x80 = unity for GAIN_W=8.
- OUT_W, 16, signed output width per side.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_samples  in  NUM_CH*SAMPLE_W  packed signed samples; ch k = bits [k*SAMPLE_W +: SAMPLE_W].
- start  in  1  sample tick; single-cycle pulse.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  4  channel index.
- cfg_wdata  in  GAIN_W+2  [GAIN_W-1:0] gain; [GAIN_W] pan-left enable; [GAIN_W+1] pan-right enable.
- out_l  out  OUT_W  signed left result.
- out_r  out  OUT_W  signed right result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- clip_l  out  1  left result saturated; qualified by out_valid.
- clip_r  out  1  right result saturated; qualified by out_valid.
- overrun  out  1  one-cycle pulse when start is dropped.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, overrides everything):
  - state=IDLE; out_l=out_r=0; out_valid=0; clip_l=clip_r=0; overrun=0.
  - All gains=unity (1<<(GAIN_W-1)); all pan=2'b11 (both sides); accumulators=0.
- States:
  - IDLE -> ACC on start. in_samples is registered into the snapshot on that edge; ch=0; acc_l=acc_r=0.
  - ACC: one channel per cycle. prod = snapshot[ch] (signed) * gain[ch] (unsigned, zero-extended).
    - acc_l += prod if pan[ch][0]; acc_r += prod if pan[ch][1].
    - ch increments; after ch=NUM_CH-1 -> SAT.
  - SAT: each side is acc >>> (GAIN_W-1) (arithmetic, floor rounding), then saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
    - Result and clip flags are registered. -> OUT.
  - OUT: out_valid=1; out_l/out_r/clip_* held stable. When out_ready=1 in a cycle with out_valid=1 -> IDLE and out_valid=0 next cycle.
- Widths:
  - Accumulator width = SAMPLE_W+GAIN_W+clog2(NUM_CH)+1, so the accumulator never wraps.
  - Gain 0xFF ≈ 1.99x.
- Latency: start high at cycle 0 -> out_valid high from cycle NUM_CH+2 (cycle 4 for NUM_CH=2).
- start while state != IDLE: dropped, no effect on the frame in progress, overrun pulses for 1 cycle. This includes start in the same cycle as the accepting out_ready.
- Config:
  - Writes are accepted in any state.
  - cfg_addr >= NUM_CH is ignored.
  - Registers are read live during ACC. A write to channel k that lands on k's ACC cycle uses the old value for that frame; a write to a not-yet-processed channel applies to the current frame.
- Pan 2'b00 = channel muted (contributes 0 to both sides).
- Reset mid-frame: abandons the frame; out_valid is 0 on the next cycle.

Test Plan:
- Reset, NUM_CH=2, defaults. start with ch0=1000, ch1=-200 -> out_valid at cycle 4, out_l=out_r=800, clip_l=clip_r=0.
- Gain: write ch0 gain=0x40, ch1 gain=0x00. Samples 1000 / 5000 -> out_l=out_r=500. Then ch0=-1001 -> -501 (floor rounding).
- Pan: ch0 pan=01 (left), ch1 pan=10 (right). Samples 1234 / -4321 -> out_l=1234, out_r=-4321. Both pan=00 -> 0 / 0.
- Saturation: unity gains.
  - 30000 + 30000 -> out_l=out_r=32767, clip_l=clip_r=1.
  - -32768 + -32768 -> -32768, clip=1.
  - 16000 + 16000 -> 32000, clip=0.
- Backpressure: hold out_ready=0 for 10 cycles -> out_l/out_r stable, out_valid stays 1. A start during this window -> overrun pulse, result unchanged. Raise out_ready -> out_valid=0 next cycle; next start produces a fresh result.
- Reset during ACC (cycle 2 after start), with ch0 gain previously set to 0x40 -> out_valid=0, busy=0 next cycle, gain reads back unity. A following start of 1000/-200 -> 800.
